sc_dmem_arbiter: RTL and testbench

SC_DMEM_ARBITER -- requirements
Module: sc_dmem_arbiter

---
 rtl/sc_dmem_pkg.sv | 16 +
 rtl/sc_wait_counter.sv | 39 +++
 rtl/sc_dmem_arbiter.sv | 119 +++++++++++
 tb/tb_sc_dmem_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sc_dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   arb_state_e     : arbiter FSM states
//   DefStarveLimit  : default number of CPU-busy WAIT cycles before the CPU is stalled
//   GrantW          : width of the completed-external-access counter
package sc_dmem_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StServe = 2'd2
  } arb_state_e;

  localparam int unsigned DefStarveLimit = 8;
  localparam int unsigned GrantW         = 16;

endpackage

// File: rtl/sc_wait_counter.sv
// Counts CPU-busy cycles spent waiting for the data-memory port.
//   clk, rst : clock and asynchronous active-high reset
//   clr_i    : restart the count at zero (takes priority over inc_i)
//   inc_i    : one more CPU-busy wait cycle
//   limit_o  : count has reached STARVE_LIMIT-1, so this busy cycle is the last one tolerated
module sc_wait_counter
  import sc_dmem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DefStarveLimit
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic limit_o
);

  logic [7:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clr_i) begin
      wait_cnt_d = 8'd0;
    end else if (inc_i) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= 8'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign limit_o = (wait_cnt_q == 8'(STARVE_LIMIT - 1));

endmodule

// File: rtl/sc_dmem_arbiter.sv
// Shares one single-cycle data-memory port between the CPU and an external requester
// (loader/debug). The CPU has priority; the external side gets the port on any cycle the CPU
// leaves it idle, and after STARVE_LIMIT busy cycles the CPU is stalled for one cycle so the
// external access is guaranteed to complete.
//   clk, rst                      : clock, asynchronous active-high reset
//   cpu_addr/wdata/we/re          : CPU access request
//   cpu_rdata, cpu_stall          : CPU load data, one-cycle freeze
//   ext_req/we/addr/wdata         : external request (held until ext_ack)
//   ext_ack, ext_rdata            : external completion pulse and read data
//   mem_addr/wdata/we, mem_rdata  : memory port (read data combinational)
//   grant_count                   : completed external accesses (wraps)
module sc_dmem_arbiter
  import sc_dmem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DefStarveLimit,
  parameter int unsigned DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [DATA_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [GrantW-1:0] grant_count
);

  arb_state_e        state_q, state_d;
  logic [GrantW-1:0] grant_count_q, grant_count_d;
  logic              cpu_busy;
  logic              ext_own;
  logic              cnt_clr, cnt_inc, cnt_limit;

  assign cpu_busy = cpu_re | cpu_we;

  sc_wait_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_wait_counter (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .limit_o(cnt_limit)
  );

  always_comb begin
    state_d   = state_q;
    ext_own   = 1'b0;
    ext_ack   = 1'b0;
    cpu_stall = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // The request's first cycle is never granted; it only arms the wait counter.
        if (ext_req) begin
          state_d = StWait;
          cnt_clr = 1'b1;
        end
      end
      StWait: begin
        if (!ext_req) begin
          // Abandoned: leave the port with the CPU so nothing external is written.
          state_d = StIdle;
        end else if (!cpu_busy) begin
          ext_own = 1'b1;
          ext_ack = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_inc = 1'b1;
          if (cnt_limit) begin
            state_d = StServe;
          end
        end
      end
      StServe: begin
        ext_own   = 1'b1;
        ext_ack   = 1'b1;
        cpu_stall = 1'b1;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // A CPU store in SERVE never reaches the port because the external side owns it.
  assign mem_addr  = ext_own ? ext_addr : cpu_addr;
  assign mem_wdata = ext_own ? ext_wdata : cpu_wdata;
  assign mem_we    = ~rst & (ext_own ? ext_we : cpu_we);
  assign cpu_rdata = mem_rdata;
  assign ext_rdata = mem_rdata;

  assign grant_count_d = grant_count_q + GrantW'(ext_ack);
  assign grant_count   = grant_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      grant_count_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_count_q <= grant_count_d;
    end
  end

endmodule

// File: tb/tb_sc_dmem_arbiter.sv
// Directed bench for sc_dmem_arbiter with a 256-word behavioural memory.
module tb_sc_dmem_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned SL = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic          cpu_we, cpu_re, cpu_stall;
  logic          ext_req, ext_we, ext_ack;
  logic [DW-1:0] ext_addr, ext_wdata, ext_rdata;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic          mem_we;
  logic [15:0]   grant_count;

  logic [DW-1:0] mem [256];

  int checks = 0;
  int errors = 0;
  int busy_ok;
  logic stall_seen, ack_seen;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
  end
  assign mem_rdata = mem[mem_addr[7:0]];

  sc_dmem_arbiter #(
    .STARVE_LIMIT(SL),
    .DATA_W      (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .cpu_re     (cpu_re),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_ack    (ext_ack),
    .ext_rdata  (ext_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .grant_count(grant_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 32'hCAFE_0001;
    rst = 1'b1;
    cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b1; cpu_re = 1'b0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;

    // Reset state; a CPU store during reset must not reach memory.
    tick();
    check_eq("rst_ack", ext_ack, 0);
    check_eq("rst_stall", cpu_stall, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_grant", grant_count, 0);
    rst = 1'b0; cpu_we = 1'b0;
    tick();

    // CPU idle external read: ack in the second cycle.
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h10;
    #1 check_eq("rd_first_cycle_ack", ext_ack, 0);
    tick();
    check_eq("rd_ack", ext_ack, 1);
    check_eq("rd_data", ext_rdata, 32'hCAFE_0001);
    check_eq("rd_stall", cpu_stall, 0);
    tick();
    ext_req = 1'b0;
    #1 check_eq("rd_grant", grant_count, 1);
    tick();

    // CPU busy loading: starvation guard forces a stall after SL busy cycles.
    cpu_re = 1'b1; cpu_addr = 32'h40;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h20; ext_wdata = 32'hA5A5_A5A5;
    #1 check_eq("starve_first_ack", ext_ack, 0);
    tick();
    busy_ok = 0;
    for (int i = 0; i < int'(SL); i++) begin
      #1;
      if (!ext_ack && !cpu_stall && mem_addr == 32'h40) busy_ok++;
      tick();
    end
    check_eq("starve_busy_cycles", busy_ok, SL);
    check_eq("serve_stall", cpu_stall, 1);
    check_eq("serve_ack", ext_ack, 1);
    check_eq("serve_mem_we", mem_we, 1);
    check_eq("serve_addr", mem_addr, 32'h20);
    tick();
    ext_req = 1'b0; ext_we = 1'b0; cpu_re = 1'b0;
    #1;
    check_eq("serve_mem", mem[8'h20], 32'hA5A5_A5A5);
    check_eq("serve_grant", grant_count, 2);
    check_eq("post_serve_stall", cpu_stall, 0);
    tick();

    // CPU store and external store collide in WAIT: CPU wins, external lands next cycle.
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h30; ext_wdata = 32'h2;
    #1 check_eq("coll_first_ack", ext_ack, 0);
    tick();
    cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h1;
    #1;
    check_eq("coll_cpu_ack", ext_ack, 0);
    check_eq("coll_cpu_wdata", mem_wdata, 32'h1);
    check_eq("coll_cpu_we", mem_we, 1);
    tick();
    cpu_we = 1'b0;
    #1;
    check_eq("coll_mem_cpu", mem[8'h30], 32'h1);
    check_eq("coll_ext_ack", ext_ack, 1);
    check_eq("coll_ext_wdata", mem_wdata, 32'h2);
    tick();
    ext_req = 1'b0; ext_we = 1'b0;
    #1;
    check_eq("coll_mem_final", mem[8'h30], 32'h2);
    check_eq("coll_grant", grant_count, 3);
    tick();

    // Abandon after three busy WAIT cycles.
    stall_seen = 1'b0; ack_seen = 1'b0;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h50; ext_wdata = 32'h55;
    cpu_re = 1'b1; cpu_addr = 32'h44;
    #1;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      stall_seen |= cpu_stall;
      ack_seen |= ext_ack;
      tick();
    end
    ext_req = 1'b0; cpu_re = 1'b0;
    #1;
    check_eq("abandon_ack", ext_ack, 0);
    check_eq("abandon_mem_we", mem_we, 0);
    tick();
    ext_we = 1'b0;
    #1;
    check_eq("abandon_grant", grant_count, 3);
    check_eq("abandon_mem", mem[8'h50], 0);
    check_eq("abandon_stall_seen", stall_seen, 0);
    check_eq("abandon_ack_seen", ack_seen, 0);
    // A fresh request must start from IDLE again (no ack in its first cycle).
    ext_req = 1'b1; ext_addr = 32'h10;
    #1 check_eq("restart_first_ack", ext_ack, 0);
    tick();
    check_eq("restart_ack", ext_ack, 1);
    tick();

    // Request held across ack: treated as a new request each time.
    for (int i = 0; i < 4; i++) begin
      check_eq("b2b_ack", ext_ack, (i % 2 == 1) ? 1 : 0);
      tick();
    end
    ext_req = 1'b0;
    #1 check_eq("b2b_grant", grant_count, 6);
    tick();

    // Reset while in SERVE.
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h60; ext_wdata = 32'hDEAD_BEEF;
    cpu_we = 1'b1; cpu_addr = 32'h64; cpu_wdata = 32'h77;
    tick();
    for (int i = 0; i < int'(SL); i++) tick();
    check_eq("pre_rst_serve_stall", cpu_stall, 1);
    rst = 1'b1;
    #1;
    check_eq("srst_ack", ext_ack, 0);
    check_eq("srst_stall", cpu_stall, 0);
    check_eq("srst_mem_we", mem_we, 0);
    check_eq("srst_grant", grant_count, 0);
    tick();
    rst = 1'b0; ext_req = 1'b0; ext_we = 1'b0; cpu_we = 1'b0;
    #1;
    check_eq("srst_no_write", mem[8'h60], 0);
    check_eq("srst_idle_ack", ext_ack, 0);
    tick();

    // Grant counter wrap.
    force dut.grant_count_q = 16'hFFFF;
    #1;
    release dut.grant_count_q;
    #1 check_eq("wrap_preload", grant_count, 16'hFFFF);
    tick();
    ext_req = 1'b1; ext_addr = 32'h10;
    #1;
    tick();
    check_eq("wrap_ack", ext_ack, 1);
    tick();
    ext_req = 1'b0;
    #1 check_eq("wrap_grant", grant_count, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
